cmp_arb: RTL and testbench

Round-robin scheduler that shares one 12-bit unsigned magnitude comparator among four requesters in the Tom video/object logic, such as timing-register and coordinate checks. Each requester presents a pair of 12-bit operands with a level request. The block grants one requester per cycle, registers the winning operands, and runs them through a single mag12-equivalent compare. Two cycles after the grant it returns a registered agb/aeb/alb result tagged with the requester id.

---
 rtl/cmp_arb.sv | 171 +++++++++++++++++
 tb/tb_cmp_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmp_arb.sv
// cmp_arb: round-robin share of one 12-bit unsigned magnitude comparator
// among four requesters.
//
//   clk        system clock, rising edge
//   resetl     asynchronous active-low reset
//   req[3:0]   level compare request per requester
//   a_in[47:0] operand A, requester i at [12i+11:12i]
//   b_in[47:0] operand B, same packing
//   gnt[3:0]   one-hot grant, combinational from req and ptr
//   res_valid  result strobe, 2 cycles after the grant
//   res_id     requester that owns the result
//   res_agb/res_aeb/res_alb  unsigned A>B / A==B / A<B (0 when !res_valid)
//
// Pipeline: grant cycle -> operand regs (vld_pipe[1]) -> result regs
// (vld_pipe[2]). One grant per cycle, no stalls, results in grant order.

// Per-requester grant decision. A lane wins when it requests and no other
// requesting lane sits closer to ptr in the rotating scan order.
module cmp_arb_lane #(
  parameter int NUM_LANES = 4,
  parameter int IDX       = 0,
  localparam int PW       = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic                 gnt
);
  logic [PW-1:0] dist_me;
  logic [PW-1:0] dist_j;
  logic          blocked;

  always_comb begin
    dist_me = PW'(IDX) - ptr;
    dist_j  = '0;
    blocked = 1'b0;
    for (int j = 0; j < NUM_LANES; j++) begin
      dist_j = PW'(j) - ptr;
      if (j != IDX && req[j] && dist_j < dist_me) blocked = 1'b1;
    end
    gnt = req[IDX] & ~blocked;
  end
endmodule

// Unsigned magnitude compare, MSB-first cascade: the first differing bit
// from the top decides; equality survives only if every bit matches.
module cmp_arb_mag #(
  parameter int VEC_W = 12
) (
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic             agb,
  output logic             aeb,
  output logic             alb
);
  logic gt_c;
  logic eq_c;

  always_comb begin
    gt_c = 1'b0;
    eq_c = 1'b1;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      gt_c = gt_c | (eq_c & a[i] & ~b[i]);
      eq_c = eq_c & (a[i] ~^ b[i]);
    end
    agb = gt_c;
    aeb = eq_c;
    alb = ~gt_c & ~eq_c;
  end
endmodule

module cmp_arb (
  input  logic        clk,
  input  logic        resetl,
  input  logic [3:0]  req,
  input  logic [47:0] a_in,
  input  logic [47:0] b_in,
  output logic [3:0]  gnt,
  output logic        res_valid,
  output logic [1:0]  res_id,
  output logic        res_agb,
  output logic        res_aeb,
  output logic        res_alb
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 12;
  localparam int PW        = $clog2(NUM_LANES);

  typedef struct packed {
    logic agb;
    logic aeb;
    logic alb;
  } res_t;

  logic [NUM_LANES-1:0][VEC_W-1:0] a_lane;
  logic [NUM_LANES-1:0][VEC_W-1:0] b_lane;
  assign a_lane = a_in;
  assign b_lane = b_in;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win_id;
  logic             gnt_any;
  logic [2:1]       vld_pipe;
  logic [PW-1:0]    id_q;
  logic [VEC_W-1:0] op_a;
  logic [VEC_W-1:0] op_b;
  res_t             cmp_res;
  res_t             res_q;
  logic [PW-1:0]    res_id_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cmp_arb_lane #(.NUM_LANES(NUM_LANES), .IDX(g)) u_lane (
      .req (req),
      .ptr (ptr),
      .gnt (gnt[g])
    );
  end

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (gnt[i]) win_id = PW'(i);
  end

  assign gnt_any = |gnt;

  // Stage 1: capture the winner; ptr moves past it so it drops to last place.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      ptr         <= '0;
      vld_pipe[1] <= 1'b0;
      id_q        <= '0;
      op_a        <= '0;
      op_b        <= '0;
    end else begin
      vld_pipe[1] <= gnt_any;
      if (gnt_any) begin
        op_a <= a_lane[win_id];
        op_b <= b_lane[win_id];
        id_q <= win_id;
        ptr  <= win_id + PW'(1);
      end
    end
  end

  cmp_arb_mag #(.VEC_W(VEC_W)) u_mag (
    .a   (op_a),
    .b   (op_b),
    .agb (cmp_res.agb),
    .aeb (cmp_res.aeb),
    .alb (cmp_res.alb)
  );

  // Stage 2: flags and id are gated by the valid so idle cycles read as 0.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      vld_pipe[2] <= 1'b0;
      res_q       <= '0;
      res_id_q    <= '0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      res_q       <= vld_pipe[1] ? cmp_res : '0;
      res_id_q    <= vld_pipe[1] ? id_q : '0;
    end
  end

  assign res_valid = vld_pipe[2];
  assign res_id    = res_id_q;
  assign res_agb   = res_q.agb;
  assign res_aeb   = res_q.aeb;
  assign res_alb   = res_q.alb;
endmodule

// File: tb/tb_cmp_arb.sv
module tb_cmp_arb;
  logic        clk = 1'b0;
  logic        resetl;
  logic [3:0]  req;
  logic [3:0][11:0] a_v;
  logic [3:0][11:0] b_v;
  logic [47:0] a_in;
  logic [47:0] b_in;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        res_agb, res_aeb, res_alb;

  int n_cmp = 0;
  int n_err = 0;

  assign a_in = a_v;
  assign b_in = b_v;

  always #5 clk = ~clk;

  cmp_arb dut (
    .clk       (clk),
    .resetl    (resetl),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_agb   (res_agb),
    .res_aeb   (res_aeb),
    .res_alb   (res_alb)
  );

  // Result bus packed as {0,0,valid,id[1:0],agb,aeb,alb}.
  function automatic logic [7:0] rv();
    return {2'b00, res_valid, res_id, res_agb, res_aeb, res_alb};
  endfunction

  function automatic logic [7:0] er(input logic v, input logic [1:0] id,
                                    input logic [2:0] f);
    return {2'b00, v, id, f};
  endfunction

  localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;
  localparam logic [7:0] IDLE = 8'h00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge; registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  sched_req [10];
  logic [3:0]  sched_gnt [10];
  logic [7:0]  sched_res [10];

  initial begin
    resetl = 1'b0;
    req    = '0;
    a_v    = '0;
    b_v    = '0;
    tick();
    tick();
    chk("reset_res", rv(), IDLE);
    chk("reset_gnt", {4'h0, gnt}, 8'h00);
    resetl = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_gnt", {4'h0, gnt}, 8'h00);
      chk("idle_res", rv(), IDLE);
    end

    // Single compare via requester 0: 0x123 > 0x122.
    tick();
    req = 4'b0001; a_v[0] = 12'h123; b_v[0] = 12'h122;
    #1 chk("single_gnt", {4'h0, gnt}, 8'h01);
    tick();
    req = 4'b0000;
    #1 chk("single_gnt_idle", {4'h0, gnt}, 8'h00);
    chk("single_n1", rv(), IDLE);
    tick();
    chk("single_res", rv(), er(1'b1, 2'd0, GT));
    tick();
    chk("single_after", rv(), IDLE);

    // Boundary operands back-to-back through requester 3 (ptr ends at 0).
    for (int c = 0; c < 6; c++) begin
      tick();
      case (c)
        0: begin a_v[3] = 12'h7FF; b_v[3] = 12'h800; end
        1: begin a_v[3] = 12'hFFF; b_v[3] = 12'h000; end
        2: begin a_v[3] = 12'h000; b_v[3] = 12'h000; end
        3: begin a_v[3] = 12'h800; b_v[3] = 12'h7FF; end
        default: ;
      endcase
      req = (c < 4) ? 4'b1000 : 4'b0000;
      #1 chk("bnd_gnt", {4'h0, gnt}, (c < 4) ? 8'h08 : 8'h00);
      case (c)
        2: chk("bnd_7ff_800", rv(), er(1'b1, 2'd3, LT));
        3: chk("bnd_fff_000", rv(), er(1'b1, 2'd3, GT));
        4: chk("bnd_000_000", rv(), er(1'b1, 2'd3, EQ));
        5: chk("bnd_800_7ff", rv(), er(1'b1, 2'd3, GT));
        default: chk("bnd_fill", rv(), IDLE);
      endcase
    end

    // Round-robin: all four requesting, equal operands, ptr starts at 0.
    for (int i = 0; i < 4; i++) begin a_v[i] = 12'h5A5; b_v[i] = 12'h5A5; end
    for (int c = 0; c < 10; c++) begin
      tick();
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1 chk("rr_gnt", {4'h0, gnt}, (c < 8) ? 8'(1 << (c % 4)) : 8'h00);
      if (c >= 2) chk("rr_res", rv(), er(1'b1, 2'((c - 2) % 4), EQ));
      else        chk("rr_fill", rv(), IDLE);
    end

    // Pointer: ptr=0 now. Grant 2 (ptr->3), then 0011 -> 0 then 1.
    a_v[2] = 12'h010; b_v[2] = 12'h020;
    a_v[0] = 12'h123; b_v[0] = 12'h122;
    sched_req[0] = 4'b0100; sched_gnt[0] = 4'b0100; sched_res[0] = IDLE;
    sched_req[1] = 4'b0011; sched_gnt[1] = 4'b0001; sched_res[1] = IDLE;
    sched_req[2] = 4'b0011; sched_gnt[2] = 4'b0010; sched_res[2] = er(1'b1, 2'd2, LT);
    sched_req[3] = 4'b0000; sched_gnt[3] = 4'b0000; sched_res[3] = er(1'b1, 2'd0, GT);
    sched_req[4] = 4'b0000; sched_gnt[4] = 4'b0000; sched_res[4] = er(1'b1, 2'd1, EQ);
    for (int c = 0; c < 5; c++) begin
      tick();
      req = sched_req[c];
      #1 chk("ptr_gnt", {4'h0, gnt}, {4'h0, sched_gnt[c]});
      chk("ptr_res", rv(), sched_res[c]);
    end

    // Reset mid-flight: ptr=2, 0011 grants 0 then 1, then reset.
    tick();
    req = 4'b0011;
    #1 chk("rst_gnt0", {4'h0, gnt}, 8'h01);
    tick();
    #1 chk("rst_gnt1", {4'h0, gnt}, 8'h02);
    tick();
    req = 4'b0000;
    resetl = 1'b0;
    #1 chk("rst_drop", rv(), IDLE);
    tick();
    chk("rst_hold", rv(), IDLE);
    resetl = 1'b1;
    tick();
    chk("rst_post0", rv(), IDLE);
    req = 4'b0100;
    #1 chk("rst_gnt2", {4'h0, gnt}, 8'h04);
    tick();
    req = 4'b0000;
    #1 chk("rst_post1", rv(), IDLE);
    tick();
    chk("rst_res2", rv(), er(1'b1, 2'd2, LT));
    tick();
    chk("rst_end", rv(), IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
